// File: rtl/glyph_font_ram.sv
// Writable glyph bitmap store for the VGA text path.
// Serves one registered read per cycle (pixel + full row), accepts pixel or
// whole-row writes, and can restore the built-in font either at reset or
// through a NUM_GLYPHS-cycle restore sequence.
module glyph_font_ram #(
    parameter int GLYPH_W    = 4,
    parameter int GLYPH_H    = 5,
    parameter int NUM_GLYPHS = 36,
    parameter int IDX_W      = 6,
    parameter int X_W        = 2,
    parameter int Y_W        = 3,
    parameter logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] DEFAULT_FONT = {
        20'h07517, 20'h07757, 20'h07111, 20'h04757, 20'h07616, 20'h05711,
        20'h07317, 20'h06247, 20'h02622, 20'h02552, 20'h07247, 20'h05522,
        20'h05225, 20'h05577, 20'h05552, 20'h05557, 20'h07222, 20'h03716,
        20'h07566, 20'h07571, 20'h07574, 20'h07557, 20'h07555, 20'h05775,
        20'h04447, 20'h05665, 20'h01157, 20'h07227, 20'h05755, 20'h07457,
        20'h07644, 20'h07647, 20'h06556, 20'h07447, 20'h06576, 20'h07575
    }
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_glyph,
    input  logic [X_W-1:0]     rd_x,
    input  logic [Y_W-1:0]     rd_y,
    output logic               rd_valid,
    output logic               rd_pixel,
    output logic [GLYPH_W-1:0] rd_row,
    input  logic               wr_en,
    input  logic               wr_row_en,
    input  logic [IDX_W-1:0]   wr_glyph,
    input  logic [X_W-1:0]     wr_x,
    input  logic [Y_W-1:0]     wr_y,
    input  logic               wr_data,
    input  logic [GLYPH_W-1:0] wr_row_data,
    input  logic               restore_req,
    output logic               busy,
    output logic               restore_done,
    output logic               wr_err
);

    localparam int GB    = GLYPH_W * GLYPH_H;
    localparam int CNT_W = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;

    typedef enum logic {IDLE, RESTORE} state_t;

    state_t                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               done_d;
    logic [NUM_GLYPHS-1:0][GB-1:0]      mem;

    logic [GB-1:0]      rd_word;
    logic [GLYPH_W-1:0] rd_row_c;
    logic               rd_pix_c;
    logic               wg_ok, wy_ok, wx_ok, wr_any, wr_ok;

    assign busy   = (state_q == RESTORE);
    assign wr_any = wr_en | wr_row_en;
    assign wr_ok  = wr_any && !busy && wg_ok && wy_ok && (wr_row_en || wx_ok);

    // Read mux: out-of-range indices simply match no entry and read as zero.
    always_comb begin
        rd_word  = '0;
        rd_row_c = '0;
        rd_pix_c = 1'b0;
        for (int g = 0; g < NUM_GLYPHS; g++) begin
            if (rd_glyph == IDX_W'(g)) rd_word = mem[g];
        end
        for (int r = 0; r < GLYPH_H; r++) begin
            if (rd_y == Y_W'(r)) rd_row_c = rd_word[(GLYPH_H-1-r)*GLYPH_W +: GLYPH_W];
        end
        for (int c = 0; c < GLYPH_W; c++) begin
            if (rd_x == X_W'(c)) rd_pix_c = rd_row_c[GLYPH_W-1-c];
        end
    end

    // Write address range checks (column only matters for pixel writes).
    always_comb begin
        wg_ok = 1'b0;
        wy_ok = 1'b0;
        wx_ok = 1'b0;
        for (int g = 0; g < NUM_GLYPHS; g++) begin
            if (wr_glyph == IDX_W'(g)) wg_ok = 1'b1;
        end
        for (int r = 0; r < GLYPH_H; r++) begin
            if (wr_y == Y_W'(r)) wy_ok = 1'b1;
        end
        for (int c = 0; c < GLYPH_W; c++) begin
            if (wr_x == X_W'(c)) wx_ok = 1'b1;
        end
    end

    // Restore sequencer next-state: walk the counter over every glyph once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (restore_req) begin
                    state_d = RESTORE;
                    cnt_d   = '0;
                end
            end
            RESTORE: begin
                if (cnt_q == CNT_W'(NUM_GLYPHS-1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, completion pulse and sticky dropped-write flag.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            restore_done <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            restore_done <= done_d;
            if (wr_any && !wr_ok) wr_err <= 1'b1;
        end
    end

    // Glyph storage: reset/restore reload the default font, otherwise accept writes.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            mem <= DEFAULT_FONT;
        end else if (busy) begin
            for (int g = 0; g < NUM_GLYPHS; g++) begin
                if (cnt_q == CNT_W'(g)) mem[g] <= DEFAULT_FONT[g*GB +: GB];
            end
        end else if (wr_ok) begin
            for (int g = 0; g < NUM_GLYPHS; g++) begin
                for (int r = 0; r < GLYPH_H; r++) begin
                    if (wr_glyph == IDX_W'(g) && wr_y == Y_W'(r)) begin
                        if (wr_row_en) begin
                            mem[g][(GLYPH_H-1-r)*GLYPH_W +: GLYPH_W] <= wr_row_data;
                        end else begin
                            for (int c = 0; c < GLYPH_W; c++) begin
                                if (wr_x == X_W'(c))
                                    mem[g][(GLYPH_H-1-r)*GLYPH_W + (GLYPH_W-1-c)] <= wr_data;
                            end
                        end
                    end
                end
            end
        end
    end

    // Registered read port; data holds until the next accepted read.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_pixel <= 1'b0;
            rd_row   <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_pixel <= rd_pix_c;
                rd_row   <= rd_row_c;
            end
        end
    end

endmodule

// File: tb/tb_glyph_font_ram.sv
// Testbench for glyph_font_ram: directed scenarios plus randomized traffic,
// with read responses checked through a scoreboard queue against a
// pixel-level reference model of the font store.
module tb_glyph_font_ram;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       rd_en;
    logic [5:0] rd_glyph;
    logic [1:0] rd_x;
    logic [2:0] rd_y;
    logic       rd_valid;
    logic       rd_pixel;
    logic [3:0] rd_row;
    logic       wr_en;
    logic       wr_row_en;
    logic [5:0] wr_glyph;
    logic [1:0] wr_x;
    logic [2:0] wr_y;
    logic       wr_data;
    logic [3:0] wr_row_data;
    logic       restore_req;
    logic       busy;
    logic       restore_done;
    logic       wr_err;

    glyph_font_ram dut (
        .clock(clock), .rst_n(rst_n),
        .rd_en(rd_en), .rd_glyph(rd_glyph), .rd_x(rd_x), .rd_y(rd_y),
        .rd_valid(rd_valid), .rd_pixel(rd_pixel), .rd_row(rd_row),
        .wr_en(wr_en), .wr_row_en(wr_row_en), .wr_glyph(wr_glyph),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_row_data(wr_row_data),
        .restore_req(restore_req), .busy(busy), .restore_done(restore_done),
        .wr_err(wr_err)
    );

    always #5 clock = ~clock;

    // Reference font, glyph 0 ('A') first; each entry is top row first, MSB = top-left.
    bit [19:0] font [36] = '{
        20'h07575, 20'h06576, 20'h07447, 20'h06556, 20'h07647, 20'h07644,
        20'h07457, 20'h05755, 20'h07227, 20'h01157, 20'h05665, 20'h04447,
        20'h05775, 20'h07555, 20'h07557, 20'h07574, 20'h07571, 20'h07566,
        20'h03716, 20'h07222, 20'h05557, 20'h05552, 20'h05577, 20'h05225,
        20'h05522, 20'h07247, 20'h02552, 20'h02622, 20'h06247, 20'h07317,
        20'h05711, 20'h07616, 20'h04757, 20'h07111, 20'h07757, 20'h07517
    };

    // Reference model state: pixel grid per glyph plus control flags.
    bit         pix_m [36][5][4];
    bit         m_busy, m_done, m_err, m_vld;
    int         m_rcnt;
    logic [4:0] sb_q [$];
    bit         mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void load_default(input int g);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 4; x++)
                pix_m[g][y][x] = font[g][(4-y)*4 + (3-x)];
    endfunction

    function automatic logic [4:0] expect_read(input int g, input int x, input int y);
        logic [3:0] row;
        logic       p;
        row = '0;
        p   = 1'b0;
        if (g < 36 && y < 5) begin
            for (int i = 0; i < 4; i++) row[3-i] = pix_m[g][y][i];
            if (x < 4) p = pix_m[g][y][x];
        end
        return {p, row};
    endfunction

    task automatic set_idle();
        rst_n = 1'b1; rd_en = 1'b0; rd_glyph = '0; rd_x = '0; rd_y = '0;
        wr_en = 1'b0; wr_row_en = 1'b0; wr_glyph = '0; wr_x = '0; wr_y = '0;
        wr_data = 1'b0; wr_row_data = '0; restore_req = 1'b0;
    endtask

    // One clock: predict from the pre-edge model, advance DUT, then advance model.
    task automatic tick();
        bit was_busy, wr_any, wr_ok;
        was_busy = m_busy;
        wr_any   = wr_en || wr_row_en;
        wr_ok    = wr_any && !was_busy && (int'(wr_glyph) < 36) && (int'(wr_y) < 5);
        if (rst_n && rd_en) sb_q.push_back(expect_read(int'(rd_glyph), int'(rd_x), int'(rd_y)));
        @(posedge clock);
        if (!rst_n) begin
            for (int g = 0; g < 36; g++) load_default(g);
            m_busy = 0; m_done = 0; m_err = 0; m_vld = 0; m_rcnt = 0;
            sb_q.delete();
        end else begin
            m_vld  = rd_en;
            m_done = 0;
            if (was_busy) begin
                load_default(m_rcnt);
                m_rcnt++;
                if (m_rcnt == 36) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (restore_req) begin
                m_busy = 1;
                m_rcnt = 0;
            end
            if (wr_ok) begin
                if (wr_row_en)
                    for (int i = 0; i < 4; i++) pix_m[wr_glyph][wr_y][i] = wr_row_data[3-i];
                else
                    pix_m[wr_glyph][wr_y][wr_x] = wr_data;
            end else if (wr_any) begin
                m_err = 1;
            end
        end
        #1;
    endtask

    // Monitor: compare control outputs every cycle, pop the scoreboard on each valid read.
    always @(negedge clock) begin
        logic [4:0] e;
        if (mon_en) begin
            chk("rd_valid", rd_valid, m_vld);
            chk("busy", busy, m_busy);
            chk("restore_done", restore_done, m_done);
            chk("wr_err", wr_err, m_err);
            if (rd_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rd_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rd_pixel", rd_pixel, e[4]);
                    chk("rd_row", rd_row, e[3:0]);
                end
            end
        end
    end

    initial begin
        int busy_cnt, done_cnt, r;
        set_idle();
        rst_n = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_row", rd_row, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wr_err", wr_err, 0);

        // Default font reads of glyph 0 ('A')
        rd_en = 1; rd_glyph = 0; rd_x = 1; rd_y = 1;
        tick();
        chk("a_valid", rd_valid, 1);
        chk("a_pix_1_1", rd_pixel, 1);
        chk("a_row_1", rd_row, 4'b0111);
        rd_y = 0;
        tick();
        chk("a_row_0", rd_row, 4'b0000);

        // Pixel write with same-cycle read (old data), then read new data
        rd_x = 0; rd_y = 0; wr_en = 1; wr_glyph = 0; wr_x = 0; wr_y = 0; wr_data = 1;
        tick();
        chk("rbw_pix", rd_pixel, 0);
        wr_en = 0;
        tick();
        chk("wr_pix", rd_pixel, 1);
        chk("wr_row", rd_row, 4'b1000);

        // Row write wins over a simultaneous pixel write
        rd_en = 0;
        wr_en = 1; wr_data = 0; wr_x = 0; wr_row_en = 1; wr_glyph = 35; wr_y = 4; wr_row_data = 4'b1010;
        tick();
        set_idle();
        rd_en = 1; rd_glyph = 35; rd_y = 4;
        tick();
        chk("rowwr_row", rd_row, 4'b1010);

        // Restore: glyphs 0 and 35 are corrupted at this point
        set_idle();
        restore_req = 1;
        tick();
        restore_req = 0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (restore_done) done_cnt++;
            wr_en = (i == 0); wr_glyph = 1; wr_data = 1;
            restore_req = (i == 5);
            tick();
        end
        set_idle();
        chk("restore_busy_cycles", busy_cnt, 36);
        chk("restore_done_pulses", done_cnt, 1);
        chk("busy_drop_wr_err", wr_err, 1);
        rd_en = 1; rd_glyph = 0; rd_x = 0; rd_y = 0;
        tick();
        chk("restored_a_pix", rd_pixel, 0);
        chk("restored_a_row", rd_row, 4'b0000);
        rd_glyph = 35; rd_y = 4;
        tick();
        chk("restored_9_row", rd_row, 4'b0111);

        // Out-of-range accesses
        set_idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        rd_en = 1; rd_glyph = 40; rd_x = 1; rd_y = 1;
        tick();
        chk("oor_glyph_valid", rd_valid, 1);
        chk("oor_glyph_pix", rd_pixel, 0);
        chk("oor_glyph_row", rd_row, 0);
        rd_en = 0;
        wr_en = 1; wr_glyph = 36; wr_x = 0; wr_y = 0; wr_data = 1;
        tick();
        wr_en = 0;
        chk("oor_wr_err", wr_err, 1);
        rd_en = 1; rd_glyph = 0; rd_x = 3; rd_y = 5;
        tick();
        chk("oor_y_pix", rd_pixel, 0);
        chk("oor_y_row", rd_row, 0);

        // Reset in the middle of a restore
        set_idle();
        restore_req = 1;
        tick();
        restore_req = 0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", restore_done, 0);
        chk("midrst_wr_err", wr_err, 0);
        rst_n = 1;
        done_cnt = 0;
        for (int g = 0; g < 36; g++) begin
            for (int y = 0; y < 5; y++) begin
                rd_en = 1; rd_glyph = 6'(g); rd_y = 3'(y); rd_x = 2'($urandom_range(0, 3));
                tick();
                if (restore_done) done_cnt++;
            end
        end
        chk("midrst_no_done", done_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rd_en    = 1'($urandom_range(0, 1));
            rd_glyph = 6'($urandom_range(0, 63));
            rd_x     = 2'($urandom_range(0, 3));
            rd_y     = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            wr_en     = (r == 0 || r == 2 || r == 3);
            wr_row_en = (r == 1 || r == 2);
            wr_glyph  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
            wr_x      = 2'($urandom_range(0, 3));
            wr_y      = 3'($urandom_range(0, 5));
            wr_data   = 1'($urandom_range(0, 1));
            wr_row_data = 4'($urandom_range(0, 15));
            restore_req = ($urandom_range(0, 149) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        set_idle();
        tick();
        tick();
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glyph_font_ram.md
# glyph_font_ram

Parametrised, writable glyph bitmap store for the VGA text path. It holds NUM_GLYPHS bitmaps of GLYPH_W×GLYPH_H pixels. It serves one registered read per cycle (a single pixel plus the full glyph row) to the character renderer. It accepts pixel or whole-row writes from the Arduino command interface, and can restore the default font either by reset or by a multi-cycle restore sequence.

## Interface
- GLYPH_W, default 4: pixels per glyph row.
- GLYPH_H, default 5: rows per glyph.
- NUM_GLYPHS, default 36: glyph count.
- IDX_W, default 6: glyph index width; must be at least clog2(NUM_GLYPHS).
- X_W, default 2: column select width; must be at least clog2(GLYPH_W).
- Y_W, default 3: row select width; must be at least clog2(GLYPH_H).
- DEFAULT_FONT, default is the standard 4×5 A–Z, 0–9 font: NUM_GLYPHS×GLYPH_W×GLYPH_H bits.
  - Glyph i occupies [i*GB +: GB], where GB = GLYPH_W×GLYPH_H.
  - Within a glyph, the MSB is the top-left pixel. Pixel (x,y) is bit (GLYPH_H-1-y)×GLYPH_W + (GLYPH_W-1-x).
  - Glyph 0 is 'A' = 20'b0000_0111_0101_0111_0101.
- clock  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rd_en  in  1  read request.
- rd_glyph  in  IDX_W  glyph to read.
- rd_x  in  X_W  pixel column to read.
- rd_y  in  Y_W  row to read.
- rd_valid  out  1  pulses one cycle after an accepted rd_en.
- rd_pixel  out  1  pixel (rd_x, rd_y) of the read glyph.
- rd_row  out  GLYPH_W  row rd_y of the read glyph; bit GLYPH_W-1 is leftmost (x=0).
- wr_en  in  1  single-pixel write.
- wr_row_en  in  1  whole-row write.
- wr_glyph  in  IDX_W  glyph to write.
- wr_x  in  X_W  pixel column to write.
- wr_y  in  Y_W  row to write.
- wr_data  in  1  pixel value for wr_en.
- wr_row_data  in  GLYPH_W  row value for wr_row_en; same bit order as rd_row.
- restore_req  in  1  start restoring the default font.
- busy  out  1  high while a restore is in progress.
- restore_done  out  1  one-cycle pulse when a restore completes.
- wr_err  out  1  sticky flag for a dropped write; cleared only by reset.

## Operation
- Storage is flops, NUM_GLYPHS×GB bits.
- Reset (rst_n=0 at a clock edge):
  - All glyphs load DEFAULT_FONT.
  - FSM returns to IDLE and the restore counter is cleared.
  - rd_valid=0, rd_pixel=0, rd_row=0, busy=0, restore_done=0, wr_err=0.
- Reads:
  - Accepted whenever rd_en=1, including while busy.
  - If rd_glyph ≥ NUM_GLYPHS, rd_x ≥ GLYPH_W or rd_y ≥ GLYPH_H, the read returns rd_pixel=0 and rd_row=0, with rd_valid still pulsed.
  - rd_row ignores rd_x. Its row-range check uses rd_glyph and rd_y only.
- Writes:
  - A write is accepted only when busy=0 and the indices are in range. wr_x is checked only for wr_en.
  - If wr_en and wr_row_en are both set, only the row write is performed.
  - A dropped write sets wr_err. Causes: busy=1, or out-of-range indices.
- Read/write to the same location in the same cycle is read-before-write: the read returns the old data.
- Restore FSM:
  - IDLE: restore_req=1 → RESTORE, counter=0, busy=1.
  - RESTORE: each cycle, glyph[counter] ← DEFAULT_FONT slice and counter increments.
  - When counter = NUM_GLYPHS-1, that glyph is written, then → IDLE with busy=0 and restore_done=1 for one cycle.
  - restore_req while busy is ignored and does not restart the sequence.
  - A restore takes exactly NUM_GLYPHS cycles.
  - Reads during RESTORE see each glyph's restored or unrestored value according to the counter position.
- Reset mid-restore immediately performs a full reset as above; no restore_done pulse is issued.

## Timing
- Read latency is 1. rd_en in cycle N gives rd_valid, rd_pixel and rd_row registered at the edge ending cycle N.
- rd_valid, rd_pixel and rd_row hold their values until the next rd_en or reset. rd_valid drops after one cycle if rd_en=0.
- A write in cycle N is visible to a read issued in cycle N+1.
- restore_req in cycle N:
  - busy=1 from cycle N+1.
  - The last glyph is written at the end of cycle N+NUM_GLYPHS.
  - busy=0 and restore_done=1 in cycle N+NUM_GLYPHS+1.
- Writes are dropped from cycle N+1 through N+NUM_GLYPHS inclusive. A write in cycle N itself is accepted.
- wr_err rises on the cycle after the offending write.

## Test plan
- Reset, then read glyph 0 at x=1, y=1 → one cycle later: rd_valid=1, rd_pixel=1, rd_row=4'b0111. Glyph 0 at y=0 → rd_row=4'b0000.
- wr_en to glyph 0 at (0,0) with wr_data=1, then read (0,0) the next cycle → rd_pixel=1, rd_row=4'b1000. In the same cycle as the write, read the same location → rd_pixel=0 (old data).
- wr_row_en to glyph 35, y=4, wr_row_data=4'b1010 while wr_en=1 with wr_data=0 → reading row 4 returns 4'b1010.
- Corrupt glyphs 0 and 35, then pulse restore_req:
  - busy stays high for exactly 36 cycles, then restore_done pulses once.
  - A wr_en during busy is dropped and wr_err=1.
  - Both glyphs read back their DEFAULT_FONT values.
- Out-of-range accesses:
  - Read rd_glyph=40 → rd_pixel=0, rd_row=0, rd_valid=1.
  - Write wr_glyph=36 → no storage change, wr_err=1.
  - Read rd_x=3, rd_y=5 → 0.
- Reset mid-restore: pulse restore_req, then assert rst_n=0 ten cycles later → next cycle busy=0, no restore_done pulse, all glyphs at default, wr_err=0.
